// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen.
// master drives pixels and observes windows; slave is the window generator.
interface conv_window_gen_if #(
   parameter int unsigned PIX_W = 12,
   parameter int unsigned X_W   = 9,
   parameter int unsigned Y_W   = 9
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sof;
   logic [PIX_W-1:0]     in_pix;
   logic                 out_valid;
   logic [9*PIX_W-1:0]   out_win;
   logic [X_W-1:0]       out_x;
   logic [Y_W-1:0]       out_y;
   logic                 out_sof;
   logic                 out_eof;

   modport master (
      output in_valid, in_sof, in_pix,
      input  in_ready, out_valid, out_win, out_x, out_y, out_sof, out_eof
   );

   modport slave (
      input  in_valid, in_sof, in_pix,
      output in_ready, out_valid, out_win, out_x, out_y, out_sof, out_eof
   );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 window generator: two line buffers plus a 3x3 register array, border taps masked by centre position.
// Define CONV_BORDER_REPLICATE_EN to replicate the nearest in-image tap instead of zero padding.
module conv_window_gen #(
   parameter int unsigned IMG_W = 400,
   parameter int unsigned IMG_H = 300,
   parameter int unsigned PIX_W = 12,
   parameter int unsigned X_W   = 9,
   parameter int unsigned Y_W   = 9
) (
   input  logic              clk_40,
   input  logic              reset,
   conv_window_gen_if.slave  bus,
   output logic              busy
);

   localparam int unsigned N   = IMG_W * IMG_H;
   localparam int unsigned L_W = $clog2(N + 1);
   localparam int unsigned P_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
   localparam logic [P_W-1:0] P_LAST = P_W'(IMG_W - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t             state;
   logic [L_W-1:0]     lcnt;
   logic [P_W-1:0]     ptr;
   logic [X_W-1:0]     cx;
   logic [Y_W-1:0]     cy;
   logic               in_ready_r;

   logic [PIX_W-1:0]   lb1 [IMG_W];
   logic [PIX_W-1:0]   lb2 [IMG_W];
   logic [PIX_W-1:0]   win  [3][3];
   logic [PIX_W-1:0]   nwin [3][3];

   logic               accept;
   logic               push;
   logic               emit;
   logic               restart;
   logic [PIX_W-1:0]   pdata;
   logic               row_ok [3];
   logic               col_ok [3];
   logic [9*PIX_W-1:0] win_masked;

   assign bus.in_ready = in_ready_r;
   assign accept       = bus.in_valid & in_ready_r;

   always_comb begin
      push    = 1'b0;
      emit    = 1'b0;
      restart = 1'b0;
      pdata   = bus.in_pix;
      unique case (state)
         IDLE: begin
            push    = accept & bus.in_sof;
            restart = accept & bus.in_sof;
         end
         FILL: begin
            push    = accept;
            restart = accept & bus.in_sof;
         end
         RUN: begin
            push    = accept;
            restart = accept & bus.in_sof;
            emit    = accept & ~bus.in_sof;
         end
         FLUSH: begin
            push  = 1'b1;
            pdata = '0;
            emit  = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         push    = 1'b0;
         emit    = 1'b0;
         restart = 1'b0;
      end
   end

   // Column 2 is the newest element; line buffers deliver the same column one and two lines earlier.
   always_comb begin
      for (int unsigned r = 0; r < 3; r++) begin
         nwin[r][0] = win[r][1];
         nwin[r][1] = win[r][2];
      end
      nwin[0][2] = lb2[ptr];
      nwin[1][2] = lb1[ptr];
      nwin[2][2] = pdata;
   end

   always_comb begin
      row_ok[0] = (cy != '0);
      row_ok[1] = 1'b1;
      row_ok[2] = (cy != Y_LAST);
      col_ok[0] = (cx != '0);
      col_ok[1] = 1'b1;
      col_ok[2] = (cx != X_LAST);
   end

   always_comb begin
`ifdef CONV_BORDER_REPLICATE_EN
      int unsigned sr;
      int unsigned sc;
      sr = 0;
      sc = 0;
`endif
      win_masked = '0;
      for (int unsigned r = 0; r < 3; r++) begin
         for (int unsigned c = 0; c < 3; c++) begin
`ifdef CONV_BORDER_REPLICATE_EN
            sr = row_ok[r] ? r : 1;
            sc = col_ok[c] ? c : 1;
            win_masked[PIX_W*(3*r+c) +: PIX_W] = nwin[sr][sc];
`else
            if (row_ok[r] && col_ok[c])
               win_masked[PIX_W*(3*r+c) +: PIX_W] = nwin[r][c];
`endif
         end
      end
   end

   // Storage is never cleared: out-of-frame contents only ever land on masked taps.
   always_ff @(posedge clk_40) begin
      if (push) begin
         lb1[ptr] <= pdata;
         lb2[ptr] <= lb1[ptr];
         for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 3; c++)
               win[r][c] <= nwin[r][c];
      end
   end

   always_ff @(posedge clk_40) begin
      if (reset) begin
         state         <= IDLE;
         lcnt          <= '0;
         ptr           <= '0;
         cx            <= '0;
         cy            <= '0;
         in_ready_r    <= 1'b1;
         busy          <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sof   <= 1'b0;
         bus.out_eof   <= 1'b0;
         bus.out_win   <= '0;
         bus.out_x     <= '0;
         bus.out_y     <= '0;
      end else begin
         bus.out_valid <= emit;
         bus.out_sof   <= emit && (cx == '0) && (cy == '0);
         bus.out_eof   <= emit && (cx == X_LAST) && (cy == Y_LAST);

         if (push)
            ptr <= (ptr == P_LAST) ? '0 : ptr + P_W'(1);

         if (emit) begin
            bus.out_win <= win_masked;
            bus.out_x   <= cx;
            bus.out_y   <= cy;
            if (cx == X_LAST) begin
               cx <= '0;
               cy <= cy + Y_W'(1);
            end else begin
               cx <= cx + X_W'(1);
            end
         end

         if (restart) begin
            state <= FILL;
            lcnt  <= L_W'(1);
            cx    <= '0;
            cy    <= '0;
            busy  <= 1'b1;
         end else begin
            unique case (state)
               FILL:
                  if (accept) begin
                     lcnt <= lcnt + L_W'(1);
                     if (lcnt == L_W'(IMG_W))
                        state <= RUN;
                  end
               RUN:
                  if (accept) begin
                     lcnt <= lcnt + L_W'(1);
                     if (lcnt == L_W'(N - 1)) begin
                        state      <= FLUSH;
                        in_ready_r <= 1'b0;
                     end
                  end
               FLUSH:
                  if ((cx == X_LAST) && (cy == Y_LAST)) begin
                     state      <= IDLE;
                     lcnt       <= '0;
                     in_ready_r <= 1'b1;
                     busy       <= 1'b0;
                  end
               default: ;
            endcase
         end
      end
   end

endmodule
